// File: rtl/mips_mem_pkg.sv
// Shared constants, region/source encodings and the address decoder for the
// mips memory responder.
package mips_mem_pkg;

    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h8002_0000;
    localparam logic [31:0] DEFAULT_STACK_TOP = 32'h8012_0000;
    localparam logic [31:0] DEFAULT_FILL      = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {REG_NONE, REG_TEXT, REG_STACK} region_t;

    // What a read port presents after its sampling edge.
    typedef enum logic [1:0] {SRC_ZERO, SRC_FILL, SRC_TEXT, SRC_STACK} src_t;

    typedef struct packed {
        region_t     region;
        logic [31:0] idx;
    } decode_t;

    // Offsets are taken only after the lower-bound test, so nothing wraps
    // across 2^32.
    function automatic decode_t decode(
        input logic [31:0] a,
        input logic [31:0] text_base,
        input logic [31:0] text_words,
        input logic [31:0] stack_top,
        input logic [31:0] stack_words
    );
        decode_t     d;
        logic [31:0] stack_base;
        stack_base = stack_top - (stack_words << 2);
        d.region   = REG_NONE;
        d.idx      = '0;
        if (a >= text_base && ((a - text_base) >> 2) < text_words) begin
            d.region = REG_TEXT;
            d.idx    = (a - text_base) >> 2;
        end else if (a >= stack_base && a < stack_top) begin
            d.region = REG_STACK;
            d.idx    = (a - stack_base) >> 2;
        end
        return d;
    endfunction

endpackage

// File: rtl/mips_mem_bank.sv
// Word-wide RAM bank: one write port and NRD registered read ports, each read
// port returning the incoming write data when it hits the word being written.
module mips_mem_bank #(
    parameter int DEPTH = 1024,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [31:0]       wdata,
    input  logic [NRD-1:0]    re,
    input  logic [AW-1:0]     raddr [NRD],
    output logic [31:0]       rdata [NRD]
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A disabled read port keeps its last word, which lets the top level hold
    // its outputs without a separate register.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [31:0] rd_reg;
            always_ff @(posedge clk) begin
                if (re[gi]) begin
                    rd_reg <= (we && waddr == raddr[gi]) ? wdata : mem[raddr[gi]];
                end
            end
            assign rdata[gi] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/mips_mem_responder.sv
// Instruction/data memory responder for the mips core: text and stack banks,
// preload port, alignment/range checking with sticky flags and a saturating count.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE   = DEFAULT_TEXT_BASE,
    parameter int          TEXT_WORDS  = 1024,
    parameter logic [31:0] STACK_TOP   = DEFAULT_STACK_TOP,
    parameter int          STACK_WORDS = 1024,
    parameter logic [31:0] FILL        = DEFAULT_FILL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_rd_wr,
    output logic [31:0] data_rdata,
    input  logic        preload_en,
    input  logic [31:0] preload_addr,
    input  logic [31:0] preload_data,
    output logic        err_misalign,
    output logic        err_range,
    output logic [7:0]  err_count
);

    localparam int TAW = $clog2(TEXT_WORDS);
    localparam int SAW = $clog2(STACK_WORDS);

    decode_t     dec_i, dec_p;
    logic [31:0] port_addr, port_wdata;
    logic        instr_mis, instr_rng, instr_ok;
    logic        port_mis, port_rng, port_ok, port_write, data_read;
    logic        text_we, stack_we;
    logic [1:0]  text_re;
    logic [0:0]  stack_re;
    logic [TAW-1:0] text_raddr [2];
    logic [SAW-1:0] stack_raddr [1];
    logic [31:0]    text_rdata [2];
    logic [31:0]    stack_rdata [1];

    src_t        instr_src_reg, data_src_reg;
    logic        err_misalign_reg, err_range_reg;
    logic [7:0]  err_count_reg;

    // Preload borrows the data port's decode path; the data port is idle then.
    assign port_addr  = preload_en ? preload_addr : data_addr;
    assign port_wdata = preload_en ? preload_data : data_wdata;
    assign port_write = preload_en | ~data_rd_wr;
    assign data_read  = ~preload_en & data_rd_wr;

    assign dec_i = decode(instr_addr, TEXT_BASE, 32'(TEXT_WORDS), STACK_TOP, 32'(STACK_WORDS));
    assign dec_p = decode(port_addr, TEXT_BASE, 32'(TEXT_WORDS), STACK_TOP, 32'(STACK_WORDS));

    assign instr_mis = |instr_addr[1:0];
    assign instr_rng = dec_i.region != REG_TEXT;
    assign instr_ok  = ~instr_mis & ~instr_rng;
    assign port_mis  = |port_addr[1:0];
    assign port_rng  = dec_p.region == REG_NONE;
    assign port_ok   = ~port_mis & ~port_rng;

    assign text_we     = reset & port_write & port_ok & (dec_p.region == REG_TEXT);
    assign stack_we    = reset & port_write & port_ok & (dec_p.region == REG_STACK);
    assign text_re[0]  = instr_ok;
    assign text_re[1]  = data_read & port_ok & (dec_p.region == REG_TEXT);
    assign stack_re[0] = data_read & port_ok & (dec_p.region == REG_STACK);
    assign text_raddr[0]  = dec_i.idx[TAW-1:0];
    assign text_raddr[1]  = dec_p.idx[TAW-1:0];
    assign stack_raddr[0] = dec_p.idx[SAW-1:0];

    mips_mem_bank #(.DEPTH(TEXT_WORDS), .NRD(2)) u_text (
        .clk   (clk),
        .we    (text_we),
        .waddr (dec_p.idx[TAW-1:0]),
        .wdata (port_wdata),
        .re    (text_re),
        .raddr (text_raddr),
        .rdata (text_rdata)
    );

    mips_mem_bank #(.DEPTH(STACK_WORDS), .NRD(1)) u_stack (
        .clk   (clk),
        .we    (stack_we),
        .waddr (dec_p.idx[SAW-1:0]),
        .wdata (port_wdata),
        .re    (stack_re),
        .raddr (stack_raddr),
        .rdata (stack_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_src_reg    <= SRC_ZERO;
            data_src_reg     <= SRC_ZERO;
            err_misalign_reg <= 1'b0;
            err_range_reg    <= 1'b0;
            err_count_reg    <= 8'h00;
        end else begin
            instr_src_reg <= instr_ok ? SRC_TEXT : SRC_FILL;
            if (data_read) begin
                if (!port_ok)
                    data_src_reg <= SRC_FILL;
                else
                    data_src_reg <= (dec_p.region == REG_TEXT) ? SRC_TEXT : SRC_STACK;
            end
            if (instr_mis | port_mis)
                err_misalign_reg <= 1'b1;
            if (instr_rng | port_rng)
                err_range_reg <= 1'b1;
            if ((!instr_ok || !port_ok) && err_count_reg != 8'hFF)
                err_count_reg <= err_count_reg + 8'd1;
        end
    end

    always_comb begin
        instr_out = 32'h0;
        case (instr_src_reg)
            SRC_TEXT: instr_out = text_rdata[0];
            SRC_FILL: instr_out = FILL;
            default:  instr_out = 32'h0;
        endcase
    end

    always_comb begin
        data_rdata = 32'h0;
        case (data_src_reg)
            SRC_TEXT:  data_rdata = text_rdata[1];
            SRC_STACK: data_rdata = stack_rdata[0];
            SRC_FILL:  data_rdata = FILL;
            default:   data_rdata = 32'h0;
        endcase
    end

    assign err_misalign = err_misalign_reg;
    assign err_range    = err_range_reg;
    assign err_count    = err_count_reg;

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the mips core's instruction-fetch and data ports. It answers instr_addr with instr_out and services data_addr reads and writes, with data_rd_wr=1 meaning read and 0 meaning write.
- It holds two word arrays: a text region at the boot PC and a stack/data region that ends at the initial stack pointer.
- It checks alignment and address range, and keeps sticky error flags and a saturating error count.
- It has a preload port that the bench or boot logic uses to load a program image before the core runs.

Parameters:
- TEXT_BASE, 32'h80020000, byte address of text word 0.
- TEXT_WORDS, 1024, text region depth in 32-bit words (power of 2).
- STACK_TOP, 32'h80120000, first byte address above the stack region.
- STACK_WORDS, 1024, stack region depth in words (power of 2); the region is [STACK_TOP-4*STACK_WORDS, STACK_TOP).
- FILL, 32'hDEADBEEF, value returned for errored reads.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- instr_addr  in  32  fetch byte address from the core.
- instr_out  out  32  fetched word; the core's instr_in.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data; the core's data_out.
- data_rd_wr  in  1  1 = read, 0 = write.
- data_rdata  out  32  load data; the core's data_in.
- preload_en  in  1  preload write strobe.
- preload_addr  in  32  preload byte address.
- preload_data  in  32  preload word.
- err_misalign  out  1  sticky: an access had addr[1:0] != 0.
- err_range  out  1  sticky: an access fell outside its legal region.
- err_count  out  8  error-cycle counter, saturating.

Behaviour:
Reset (reset=0, asynchronous):
- instr_out, data_rdata and err_count go to 0; err_misalign and err_range go to 0.
- Array contents are NOT cleared; memory is retained across reset.
- While reset is low, no writes are performed.

Latency:
- Both read ports are registered with a 1-cycle latency. The address sampled at posedge N appears on the output after posedge N.
- Outputs hold their value until the next posedge.

Region decode (combinational, on the full 32-bit address):
- TEXT: TEXT_BASE <= a < TEXT_BASE + 4*TEXT_WORDS.
- STACK: STACK_TOP - 4*STACK_WORDS <= a < STACK_TOP.
- Anything else is NONE.
- Word index = (a - region base) >> 2. Width rule: unsigned 32-bit compare; no wrap across 2^32.

Instruction port:
- Legal only in TEXT with a[1:0] = 0; then instr_out <= text[idx].
- Otherwise instr_out <= FILL, and err_range and/or err_misalign are set.

Data read (data_rd_wr=1):
- Legal in TEXT or STACK when aligned; then data_rdata <= word.
- Otherwise data_rdata <= FILL and the matching error flag is set.

Data write (data_rd_wr=0):
- Legal in TEXT or STACK when aligned; the array is updated at the posedge.
- Otherwise the write is dropped and the error flag is set.
- data_rdata holds its previous value during a write cycle.
- A write held for several cycles rewrites the same word each cycle, which is idempotent. The core holds data_rd_wr low from ME through WB, and this is legal.

Preload:
- preload_en=1 has priority over the data port. The data port is ignored that cycle: no read update, no write, no error.
- Preload writes use the same decode. An out-of-range or misaligned preload is dropped and sets the error flags.

Collision:
- When the same word is written (data or preload) and read (instr or data) in the same cycle, the read is write-first and returns the new data.

Errors:
- err_count increments by 1 in any cycle with at least one error event, whether on one port or both.
- It saturates at 8'hFF.
- Flags and count clear only on reset.

Decomposition:
- Package mips_mem_pkg holds:
  - the default TEXT_BASE, STACK_TOP and FILL constants;
  - typedef enum region_t {REG_NONE, REG_TEXT, REG_STACK};
  - a decode function returning region_t and the index.
- Sub-module mips_mem_bank: one write port and two registered read ports with write-first bypass, parameterised by depth. It is instanced once for TEXT and once for STACK.
- The top level muxes the bank outputs by the region registered at the sampling edge.

Test Plan:
1. Preload text[0..1] = 32'h27BDFFF8 and 32'h00000000, release reset, drive instr_addr=32'h80020004 -> instr_out = 0 one cycle later, and instr_out = 32'h27BDFFF8 one cycle after instr_addr=32'h80020000.
2. Write 32'hCAFEF00D to data_addr 32'h8011FFFC with data_rd_wr=0 for 2 cycles, then read it back -> data_rdata = 32'hCAFEF00D, err_count = 0.
3. Read data_addr 32'h80120000 (first address above STACK_TOP) -> data_rdata = 32'hDEADBEEF, err_range = 1, err_count = 1; a write there leaves the array unchanged.
4. Set instr_addr = 32'h80020002 -> instr_out = FILL and err_misalign = 1. In the same cycle also issue an out-of-range data read -> err_count increments by exactly 1.
5. Write to 32'h80020008 while instr_addr = 32'h80020008 in the same cycle -> instr_out equals the new data (write-first).
6. Force 300 error cycles, then pulse reset low mid-cycle:
   - before reset: err_count = 8'hFF;
   - after the asynchronous reset: outputs and flags = 0;
   - afterwards: the previously written 32'hCAFEF00D still reads back.
